// File: rtl/register_pipe_flow_ctrl.sv
// register_pipe_flow_ctrl
// Valid/ready flow controller for a PIPE_DEPTH-stage register pipeline.
// Drives the per-stage clock enables of an external datapath so that it
// behaves as an elastic pipeline. Empty stages are collapsed while the
// output is stalled, and flush drops every word still in flight.
// Optional feature: define REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN to add a
// saturating stall_count output. It counts the cycles in which the output
// word waits on downstream.
module register_pipe_flow_ctrl #(
   parameter int PIPE_DEPTH        = 4,
   parameter int COUNT_WIDTH       = $clog2(PIPE_DEPTH + 1),
   parameter int STALL_COUNT_WIDTH = 16
) (
   input  logic                         clock,
   input  logic                         clear,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PIPE_DEPTH-1:0]        stage_enable,
   output logic [PIPE_DEPTH-1:0]        stage_valid,
   output logic [COUNT_WIDTH-1:0]       occupancy
`ifdef REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN
   ,
   output logic [STALL_COUNT_WIDTH-1:0] stall_count
`endif
);

   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 64) begin : g_bad_depth
      $error("register_pipe_flow_ctrl: PIPE_DEPTH must be in 1..64");
   end
   if (STALL_COUNT_WIDTH < 1) begin : g_bad_stall_width
      $error("register_pipe_flow_ctrl: STALL_COUNT_WIDTH must be at least 1");
   end

   logic [PIPE_DEPTH-1:0]  valid;
   logic [PIPE_DEPTH-1:0]  valid_nxt;
   logic [PIPE_DEPTH-1:0]  rdy;
   logic [PIPE_DEPTH-1:0]  up;
   logic [COUNT_WIDTH-1:0] occ_q;

   // Ready chain: a stage can take a word if it is empty or its successor can move.
   always_comb begin
      rdy = '0;
      rdy[PIPE_DEPTH-1] = out_ready | ~valid[PIPE_DEPTH-1];
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
         rdy[PIPE_DEPTH-1-k] = ~valid[PIPE_DEPTH-1-k] | rdy[PIPE_DEPTH-k];
      end
   end

   // Upstream valid per stage: stage 0 sees the input, stage i sees stage i-1.
   always_comb begin
      up    = '0;
      up[0] = in_valid;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
         up[i] = valid[i-1];
      end
   end

   // Next valid bits when neither clear nor flush is active.
   always_comb begin
      valid_nxt = valid;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         if (rdy[i]) begin
            valid_nxt[i] = up[i];
         end
      end
   end

   // Valid bits and occupancy, updated together. Clear overrides flush.
   always_ff @(posedge clock) begin
      if (clear) begin
         valid <= '0;
         occ_q <= '0;
      end else if (flush) begin
         valid <= '0;
         occ_q <= '0;
      end else begin
         valid <= valid_nxt;
         occ_q <= COUNT_WIDTH'($countones(valid_nxt));
      end
   end

   // Handshake outputs and datapath enables.
   always_comb begin
      in_ready     = rdy[0] & ~clear;
      out_valid    = valid[PIPE_DEPTH-1];
      stage_enable = rdy & up & {PIPE_DEPTH{~clear & ~flush}};
      stage_valid  = valid;
      occupancy    = occ_q;
   end

`ifdef REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN
   logic [STALL_COUNT_WIDTH-1:0] stall_q;

   // Saturating count of the cycles in which the output word waits on downstream. Flush does not reset it.
   always_ff @(posedge clock) begin
      if (clear) begin
         stall_q <= '0;
      end else if (valid[PIPE_DEPTH-1] && !out_ready && !(&stall_q)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_register_pipe_flow_ctrl.sv
// tb_register_pipe_flow_ctrl
// Scoreboard bench for register_pipe_flow_ctrl (PIPE_DEPTH=4) driving a
// model datapath through stage_enable. Stall counter checks are compiled
// only when REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN is defined.
module tb_register_pipe_flow_ctrl;

   localparam int D = 4;

   logic         clock = 1'b0;
   logic         clear;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [D-1:0] stage_enable;
   logic [D-1:0] stage_valid;
   logic [2:0]   occupancy;
   logic [7:0]   pipe_in;
   logic [7:0]   dp [D];

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb [$];

   always #5 clock = ~clock;

`ifdef REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN
   logic [15:0]  stall_count;
   logic [3:0]   stall_small;
   logic         s_in_ready, s_out_valid;
   logic [D-1:0] s_stage_enable, s_stage_valid;
   logic [2:0]   s_occupancy;

   register_pipe_flow_ctrl #(.PIPE_DEPTH(D), .STALL_COUNT_WIDTH(4)) dut_small (
      .clock(clock), .clear(clear), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .stage_enable(s_stage_enable), .stage_valid(s_stage_valid),
      .occupancy(s_occupancy), .stall_count(stall_small)
   );
`endif

   register_pipe_flow_ctrl #(.PIPE_DEPTH(D)) dut (
      .clock(clock), .clear(clear), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .stage_enable(stage_enable), .stage_valid(stage_valid),
      .occupancy(occupancy)
`ifdef REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   // Datapath model: one register per stage, loaded on stage_enable.
   always @(posedge clock) begin
      for (int i = 0; i < D; i++) begin
         if (stage_enable[i]) dp[i] <= (i == 0) ? pipe_in : dp[i-1];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares output transfers against the scoreboard and records input transfers.
   always @(negedge clock) begin
      if (!clear && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got word %0d expected no output (t=%0t)", dp[D-1], $time);
         end else begin
            chk("out_data", {56'd0, dp[D-1]}, {56'd0, sb.pop_front()});
         end
      end
      if (clear || flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(pipe_in);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
      in_valid  = v;
      pipe_in   = d;
      out_ready = ordy;
   endtask

   initial begin
      int exp_occ;
      int bub_occ [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
      clear = 1'b1;
      flush = 1'b0;
      drive(1'b1, 8'd99, 1'b1);

      // Reset
      @(negedge clock);
      chk("clear_in_ready", in_ready, 0);
      chk("clear_stage_enable", stage_enable, 0);
      tick();
      clear = 1'b0;
      drive(1'b0, 8'd0, 1'b1);
      @(negedge clock);
      chk("reset_stage_valid", stage_valid, 0);
      chk("reset_occupancy", occupancy, 0);
      chk("reset_out_valid", out_valid, 0);
      tick();

      // Streaming 1..8 at full rate
      for (int k = 0; k <= 12; k++) begin
         if (k < 8) drive(1'b1, 8'(k + 1), 1'b1);
         else drive(1'b0, 8'd0, 1'b1);
         @(negedge clock);
         exp_occ = (k < 4) ? k : (k <= 8) ? 4 : 12 - k;
         chk("stream_out_valid", out_valid, (k >= 4 && k <= 11));
         chk("stream_occupancy", occupancy, exp_occ);
         if (k < 8) chk("stream_in_ready", in_ready, 1);
         tick();
      end

      // Bubble collapse with downstream stalled
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) drive(1'b1, 8'(11 + k / 2), 1'b0);
         else drive(1'b0, 8'd0, 1'b0);
         if (k == 7) drive(1'b1, 8'd15, 1'b0);
         @(negedge clock);
         chk("bubble_occupancy", occupancy, bub_occ[k]);
         if (k == 6) chk("bubble_in_ready_last_slot", in_ready, 1);
         if (k == 7) begin
            chk("bubble_full_in_ready", in_ready, 0);
            chk("bubble_full_out_valid", out_valid, 1);
         end
         tick();
      end
      drive(1'b1, 8'd15, 1'b1);
      @(negedge clock);
      chk("bubble_passthru_in_ready", in_ready, 1);
      tick();
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clock);
      chk("bubble_refill_occupancy", occupancy, 4);
      chk("bubble_refill_in_ready", in_ready, 0);
      tick();
      drive(1'b0, 8'd0, 1'b1);
      repeat (5) tick();
      @(negedge clock);
      chk("bubble_drained_occupancy", occupancy, 0);
      tick();

      // Flush while full
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 8'(21 + k), 1'b0);
         tick();
      end
      flush = 1'b1;
      drive(1'b1, 8'd25, 1'b1);
      @(negedge clock);
      chk("flush_full_occupancy", occupancy, 4);
      chk("flush_stage_enable", stage_enable, 0);
      chk("flush_out_valid", out_valid, 1);
      tick();
      flush = 1'b0;
      drive(1'b0, 8'd0, 1'b1);
      @(negedge clock);
      chk("flush_after_occupancy", occupancy, 0);
      chk("flush_after_out_valid", out_valid, 0);
      chk("flush_after_stage_valid", stage_valid, 0);
      repeat (6) tick();

      // Clear mid-stream with three words in flight
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'(31 + k), 1'b0);
         tick();
      end
      clear = 1'b1;
      drive(1'b1, 8'd34, 1'b0);
      @(negedge clock);
      chk("midclear_occupancy_before", occupancy, 3);
      chk("midclear_in_ready", in_ready, 0);
      chk("midclear_stage_enable", stage_enable, 0);
      tick();
      clear = 1'b0;
      drive(1'b0, 8'd0, 1'b1);
      @(negedge clock);
      chk("midclear_stage_valid", stage_valid, 0);
      chk("midclear_occupancy", occupancy, 0);
      chk("midclear_out_valid", out_valid, 0);
      repeat (6) tick();

`ifdef REGISTER_PIPE_FLOW_CTRL_STALL_COUNT_EN
      // Stall counter: count, saturate, survive flush
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clock);
      chk("stall_reset", stall_count, 0);
      tick();
      drive(1'b1, 8'd41, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (out_valid) break;
         tick();
      end
      chk("stall_wait_out_valid", out_valid, 1);
      chk("stall_before", stall_count, 0);
      repeat (10) tick();
      @(negedge clock);
      chk("stall_10", stall_count, 10);
      chk("stall_small_10", stall_small, 10);
      repeat (10) tick();
      @(negedge clock);
      chk("stall_20", stall_count, 20);
      chk("stall_small_sat", stall_small, 15);
      tick();
      @(negedge clock);
      chk("stall_small_hold_sat", stall_small, 15);
      tick();
      flush = 1'b1;
      drive(1'b0, 8'd0, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clock);
      chk("stall_after_flush", stall_count, 22);
      chk("stall_small_after_flush", stall_small, 15);
      chk("stall_after_flush_out_valid", out_valid, 0);
      tick();
`endif

      @(negedge clock);
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
